// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - request/status bundle between a FIFO user and fifo_ctrl
// Purpose: groups the request inputs, memory drive and status outputs of fifo_ctrl.
// Ports (modport slave = controller side, master = user side):
//   wr_en, rd_en, flush, thresh : requests and threshold from the user
//   waddr, raddr, wclken, wfull : fifomem drive
//   empty, full, count, thresh_hit : status
//   overflow, underflow, err_clr : sticky error flags, only with FIFO_CTRL_ERR_EN
interface fifo_ctrl_if #(
    parameter int ADDRSIZE = 4
);
    logic                wr_en;
    logic                rd_en;
    logic                flush;
    logic [ADDRSIZE:0]   thresh;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE-1:0] raddr;
    logic                wclken;
    logic                wfull;
    logic                empty;
    logic                full;
    logic [ADDRSIZE:0]   count;
    logic                thresh_hit;
`ifdef FIFO_CTRL_ERR_EN
    logic                overflow;
    logic                underflow;
    logic                err_clr;

    modport master (
        output wr_en, rd_en, flush, thresh, err_clr,
        input  waddr, raddr, wclken, wfull, empty, full, count, thresh_hit,
               overflow, underflow
    );
    modport slave (
        input  wr_en, rd_en, flush, thresh, err_clr,
        output waddr, raddr, wclken, wfull, empty, full, count, thresh_hit,
               overflow, underflow
    );
`else
    modport master (
        output wr_en, rd_en, flush, thresh,
        input  waddr, raddr, wclken, wfull, empty, full, count, thresh_hit
    );
    modport slave (
        input  wr_en, rd_en, flush, thresh,
        output waddr, raddr, wclken, wfull, empty, full, count, thresh_hit
    );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - single-clock pointer/flag controller for a fifomem-based FWFT FIFO
// Purpose: generates fifomem addresses and write enable, and decodes empty/full/
//   count/threshold status from the wrap-bit read and write pointers.
// Ports:
//   clk  : clock (also fifomem.wclk)
//   rst  : asynchronous active-high reset
//   bus  : fifo_ctrl_if.slave (requests in; memory drive and status out)
// Optional feature: define FIFO_CTRL_ERR_EN for sticky overflow/underflow flags
//   cleared by err_clr.
module fifo_ctrl #(
    parameter int ADDRSIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    fifo_ctrl_if.slave  bus
);
    localparam logic [ADDRSIZE:0] PTR_ONE = (ADDRSIZE+1)'(1);

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic              empty_i;
    logic              full_i;
    logic [ADDRSIZE:0] count_i;
    logic              wa;
    logic              ra;

    // Status comes only from the pointer registers; the wrap bit separates
    // full (MSBs differ, low bits equal) from empty (pointers identical).
    assign empty_i = (wptr == rptr);
    assign full_i  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                     (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count_i = wptr - rptr;

    // A full FIFO never accepts a write even with a same-cycle read, and an
    // empty one never accepts a read even with a same-cycle write.
    assign wa = bus.wr_en & ~full_i & ~bus.flush;
    assign ra = bus.rd_en & ~empty_i & ~bus.flush;

    assign bus.waddr      = wptr[ADDRSIZE-1:0];
    assign bus.raddr      = rptr[ADDRSIZE-1:0];
    assign bus.wclken     = wa;
    assign bus.wfull      = full_i;
    assign bus.empty      = empty_i;
    assign bus.full       = full_i;
    assign bus.count      = count_i;
    assign bus.thresh_hit = (bus.thresh != '0) && (count_i >= bus.thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wa) wptr <= wptr + PTR_ONE;
            if (ra) rptr <= rptr + PTR_ONE;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // The set term is applied after the clear so a coincident event wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.err_clr) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            if (bus.wr_en & full_i & ~bus.flush)  overflow_q  <= 1'b1;
            if (bus.rd_en & empty_i & ~bus.flush) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl with a behavioural fifomem
module tb_fifo_ctrl;
    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 1 << ADDRSIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.ADDRSIZE(ADDRSIZE)) bus ();

    fifo_ctrl #(.ADDRSIZE(ADDRSIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural fifomem: registered write, combinational read.
    logic [7:0] mem [DEPTH];
    logic [7:0] wdata;
    logic [7:0] rdata;
    always @(posedge clk) if (bus.wclken && !bus.wfull) mem[bus.waddr] <= wdata;
    assign rdata = mem[bus.raddr];

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];

    int         m_count = 0;
    logic [4:0] m_wptr  = '0;
    logic [4:0] m_rptr  = '0;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read must present the oldest outstanding word.
    always @(negedge clk) begin
        if (!rst && bus.rd_en && !bus.empty && !bus.flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata: unexpected read, got %0h expected none", rdata);
            end else begin
                chk("rdata", {24'h0, rdata}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_status();
        chk("count",      bus.count, m_count);
        chk("empty",      bus.empty, m_count == 0);
        chk("full",       bus.full,  m_count == DEPTH);
        chk("waddr",      bus.waddr, m_wptr[3:0]);
        chk("raddr",      bus.raddr, m_rptr[3:0]);
        chk("thresh_hit", bus.thresh_hit, (bus.thresh != 0) && (m_count >= int'(bus.thresh)));
`ifdef FIFO_CTRL_ERR_EN
        chk("overflow",   bus.overflow,  m_ovf);
        chk("underflow",  bus.underflow, m_unf);
`endif
    endtask

    // One clock cycle of stimulus with model update at the following edge.
    task automatic cyc(input logic wr, input logic rd, input logic fl, input logic [7:0] d,
                       input logic eclr = 1'b0);
        logic wacc;
        logic racc;
        @(posedge clk);
        #1;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.flush = fl;
        wdata     = d;
`ifdef FIFO_CTRL_ERR_EN
        bus.err_clr = eclr;
`endif
        wacc = wr && !fl && (m_count < DEPTH);
        racc = rd && !fl && (m_count > 0);
        if (wacc) exp_q.push_back(d);
        @(negedge clk);
        check_status();
        chk("wclken", bus.wclken, wacc);
        #2;
        if (eclr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (wr && !fl && m_count == DEPTH) m_ovf = 1'b1;
        if (rd && !fl && m_count == 0)     m_unf = 1'b1;
        if (fl) begin
            m_wptr = '0;
            m_rptr = '0;
            exp_q.delete();
        end else begin
            if (wacc) m_wptr = m_wptr + 5'd1;
            if (racc) m_rptr = m_rptr + 5'd1;
        end
        m_count = int'(5'(m_wptr - m_rptr));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        bus.flush  = 1'b0;
        bus.thresh = '0;
        wdata      = '0;
`ifdef FIFO_CTRL_ERR_EN
        bus.err_clr = 1'b0;
`endif
        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_status();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill with 0x01..0x10, then a 17th write is refused.
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        idle();
        chk("full_after_16", bus.full, 1'b1);
        chk("count_after_16", bus.count, 16);
        cyc(1'b1, 1'b0, 1'b0, 8'hEE);
        idle();

        // Drain 16 words in order, then an extra read must not move raddr.
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        idle();
        chk("empty_after_drain", bus.empty, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        idle();
        chk("raddr_after_underread", bus.raddr, 4'h0);

`ifdef FIFO_CTRL_ERR_EN
        // Clear coinciding with a new underflow event leaves the flag set.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
`endif

        // Hold count=8 with concurrent read/write for 40 cycles; pointers wrap.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 8'h40 + 8'(i));
        idle();
        chk("count_steady", bus.count, 8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        idle();

        // Full with both requests: read wins, write dropped.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'h80 + 8'(i));
        cyc(1'b1, 1'b1, 1'b0, 8'hFF);
        idle();
        chk("count_full_rw", bus.count, 15);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        // Empty with both requests: write wins, read dropped.
        cyc(1'b1, 1'b1, 1'b0, 8'hA5);
        idle();
        chk("count_empty_rw", bus.count, 1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

        // Threshold at 5, then flush.
        bus.thresh = 5'd5;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
        idle();
        chk("thresh_hit_at_5", bus.thresh_hit, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'hDD);
        idle();
        chk("flush_empty", bus.empty, 1'b1);
        chk("flush_thresh", bus.thresh_hit, 1'b0);

        // thresh=0 keeps thresh_hit low up to full; thresh>DEPTH never fires.
        bus.thresh = 5'd0;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
        idle();
        bus.thresh = 5'd17;
        idle();
        bus.thresh = 5'd16;
        idle();

        // Asynchronous reset mid-operation clears state without a clock edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_empty", bus.empty, 1'b1);
        chk("async_rst_waddr", bus.waddr, 4'h0);
        m_count = 0;
        m_wptr  = '0;
        m_rptr  = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.thresh = 5'd0;
        cyc(1'b1, 1'b0, 1'b0, 8'h5A);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Single-clock pointer and flag controller that sequences one `fifomem` instance as a synchronous FIFO for the UART TX and RX paths. It generates `waddr`, `raddr`, `wclken` and `wfull` for the memory and presents empty, full, fill-count and threshold status to the APB register block. Read data comes from the memory's combinational port, so the FIFO is first-word-fall-through: `rdata` is valid whenever `empty` is low.

## Interface
Parameters:
- `ADDRSIZE`, default 4: memory address bits. Must match `fifomem.ADDRSIZEl`. Depth is `1<<ADDRSIZE`.

Ports:
- `clk`  in  1: the single clock. Drives this block and `fifomem.wclk`.
- `rst`  in  1: asynchronous reset, active-high.
- `wr_en`  in  1: write request. The data word is on `fifomem.wdata` in the same cycle.
- `rd_en`  in  1: read request. Consumes the word currently on `fifomem.rdata`.
- `flush`  in  1: synchronous clear of FIFO contents.
- `thresh`  in  ADDRSIZE+1: fill-level threshold.
- `waddr`  out  ADDRSIZE: memory write address.
- `raddr`  out  ADDRSIZE: memory read address.
- `wclken`  out  1: memory write enable.
- `wfull`  out  1: memory write inhibit.
- `empty`  out  1: FIFO holds 0 words.
- `full`  out  1: FIFO holds DEPTH words.
- `count`  out  ADDRSIZE+1: current fill level, 0..DEPTH.
- `thresh_hit`  out  1: high when `count >= thresh` and `thresh != 0`.
- `overflow`  out  1: sticky flag. Present only when `FIFO_CTRL_ERR_EN` is defined.
- `underflow`  out  1: sticky flag. Present only when `FIFO_CTRL_ERR_EN` is defined.
- `err_clr`  in  1: clears both sticky flags. Present only when `FIFO_CTRL_ERR_EN` is defined.

## Operation
- State consists of the registers `wptr` and `rptr`, each ADDRSIZE+1 bits with a wrap bit in the MSB.
- Address outputs: `waddr = wptr[ADDRSIZE-1:0]`, `raddr = rptr[ADDRSIZE-1:0]`.
- Status decode:
  - `empty = (wptr == rptr)`.
  - `full = (wptr[MSB] != rptr[MSB]) && (low bits equal)`.
  - `count = wptr - rptr`, computed modulo 2^(ADDRSIZE+1).
- Accepted operations:
  - Write accepted: `wa = wr_en & ~full & ~flush`.
  - Read accepted: `ra = rd_en & ~empty & ~flush`.
- Memory drive: `wclken = wa`, `wfull = full`. Memory gating is therefore consistent with the controller's own acceptance decision.
- Pointer update: `wptr` increments on `wa`; `rptr` increments on `ra`. Both pointers wrap naturally at 2^(ADDRSIZE+1).
- Simultaneous write and read:
  - Not full and not empty: both are accepted and `count` is unchanged.
  - Full: the read is accepted and the write is dropped. A same-cycle read does not free space for a write.
  - Empty: the write is accepted and the read is dropped. There is no bypass.
- Flush: on `flush`, both pointers load 0 at the next edge. Flush has priority over all requests and the memory is not written.
- Threshold: `thresh_hit` is combinational from the registered pointers. `thresh == 0` forces it low. `thresh > DEPTH` never asserts it.
- Outputs are decoded from pointer registers only, with no combinational path from request inputs to status. The exception is `wclken`, which depends on `wr_en` and `flush`.

## Timing
- Reset: `wptr = rptr = 0`. Resulting outputs: `empty=1`, `full=0`, `count=0`, `waddr=raddr=0`, `thresh_hit=0`, `overflow=underflow=0`.
- Write latency: the data is stored at the edge where `wa` is high. At the following cycle `empty=0` and `rdata` already shows the word.
- Read latency: `rdata` is valid in the same cycle as `rd_en`. `raddr` advances at the edge.
- Status flags and `count` update one cycle after the accepting edge.
- Reset asserted mid-operation: pointers and flags clear immediately. Memory contents are not cleared but are unreachable.

## Configuration
- Macro: `FIFO_CTRL_ERR_EN`.
- Defined:
  - `overflow` is set on `wr_en & full & ~flush`.
  - `underflow` is set on `rd_en & empty & ~flush`.
  - Both are sticky until `err_clr` or `rst`.
  - If `err_clr` and a set event occur in the same cycle, the flag ends set.
- Undefined: the `overflow`, `underflow` and `err_clr` ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset with `ADDRSIZE=4` -> `empty=1`, `full=0`, `count=0`, `waddr=raddr=0`.
- Write 0x01..0x10 on 16 consecutive cycles -> `full=1`, `count=16`. A 17th write gives `wclken=0`, `count` stays 16, and `overflow=1` when the macro is defined.
- Read 16 words from full -> data is 0x01..0x10 in order with `rdata` valid in the `rd_en` cycle. Then `empty=1`. A further read leaves `raddr` unchanged and sets `underflow=1`.
- Hold `count=8` while asserting `wr_en` and `rd_en` together for 40 cycles -> `count` stays 8, both pointers wrap past 31 to 0, and data order is preserved.
- Full FIFO with `wr_en=rd_en=1` -> read accepted, write dropped, `count=15`. Empty FIFO with both high -> write accepted, `count=1`.
- Set `thresh=5` and write 5 words -> `thresh_hit` rises on the cycle after the 5th write. Then `flush` -> `count=0`, `thresh_hit=0`, `empty=1`. With `thresh=0`, `thresh_hit` stays low at any fill level.
